// File: rtl/stc_detector_if.sv
// Detection-side bus of stc_detector: sweep trigger, video samples and the
// single-entry detection record with its ready/valid handshake.
interface stc_detector_if;
  logic        trig;
  logic [11:0] vid_in;
  logic        det_ready;
  logic        det_valid;
  logic [11:0] det_range;
  logic [11:0] det_width;
  logic [11:0] det_peak;
  logic [7:0]  drop_cnt;
  logic        busy;

  modport master (
    output trig, vid_in, det_ready,
    input  det_valid, det_range, det_width, det_peak, drop_cnt, busy
  );

  modport slave (
    input  trig, vid_in, det_ready,
    output det_valid, det_range, det_width, det_peak, drop_cnt, busy
  );
endinterface

// File: rtl/stc_detector.sv
// Range-sweep run detector: finds runs of above-threshold bins and reports them
// through a 1-entry buffer. Define STC_DETECTOR_PEAK_EN to enable peak tracking.
module stc_detector #(
  parameter logic [11:0] SAMPLE_LIMIT = 12'd2626,
  parameter logic [11:0] THRESHOLD    = 12'd512,
  parameter logic [11:0] MIN_RUN      = 12'd3
) (
  input  logic          clk,
  input  logic          rst,
  stc_detector_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RUN    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] bin_q, bin_d;
  logic [11:0] start_q, start_d;
  logic [11:0] width_q, width_d;
  logic        busy_q;
  logic        det_valid_q, det_valid_d;
  logic [11:0] det_range_q, det_range_d;
  logic [11:0] det_width_q, det_width_d;
  logic [7:0]  drop_q, drop_d;

  logic        in_sweep, above, last_bin, run_open;
  logic        close_run, report, load;
  logic [11:0] cur_bin;

  // A trig always starts bin 0 and discards whatever run was open.
  assign in_sweep = bus.trig || (state_q != IDLE);
  assign cur_bin  = bus.trig ? 12'd0 : bin_q;
  assign above    = (bus.vid_in >= THRESHOLD);
  assign last_bin = (cur_bin == (SAMPLE_LIMIT - 12'd1));
  assign run_open = (state_q == RUN) && !bus.trig;

  // NOTE: every always_comb output is given its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    start_d   = start_q;
    width_d   = width_q;
    close_run = 1'b0;
    if (in_sweep) begin
      bin_d = last_bin ? 12'd0 : cur_bin + 12'd1;
      if (above) begin
        state_d = RUN;
        if (run_open) begin
          width_d = (width_q == 12'hFFF) ? width_q : width_q + 12'd1;
        end else begin
          start_d = cur_bin;
          width_d = 12'd1;
        end
        close_run = last_bin;
      end else begin
        state_d   = SEARCH;
        close_run = run_open;
      end
      if (last_bin) state_d = IDLE;
    end
  end

  // start_d/width_d already hold the closed run in both closing cases.
  assign report = close_run && (width_d >= MIN_RUN);
  assign load   = report && (!det_valid_q || bus.det_ready);

  always_comb begin
    det_valid_d = det_valid_q;
    det_range_d = det_range_q;
    det_width_d = det_width_q;
    drop_d      = drop_q;
    if (load) begin
      det_valid_d = 1'b1;
      det_range_d = start_d;
      det_width_d = width_d;
    end else if (report) begin
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (det_valid_q && bus.det_ready) begin
      det_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      start_q     <= '0;
      width_q     <= '0;
      busy_q      <= 1'b0;
      det_valid_q <= 1'b0;
      det_range_q <= '0;
      det_width_q <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      start_q     <= start_d;
      width_q     <= width_d;
      busy_q      <= (state_d != IDLE);
      det_valid_q <= det_valid_d;
      det_range_q <= det_range_d;
      det_width_q <= det_width_d;
      drop_q      <= drop_d;
    end
  end

`ifdef STC_DETECTOR_PEAK_EN
  logic [11:0] peak_q, peak_d;
  logic [11:0] det_peak_q, det_peak_d;

  always_comb begin
    peak_d = peak_q;
    if (in_sweep && above) begin
      peak_d = (run_open && (peak_q > bus.vid_in)) ? peak_q : bus.vid_in;
    end
    det_peak_d = load ? peak_d : det_peak_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_q     <= '0;
      det_peak_q <= '0;
    end else begin
      peak_q     <= peak_d;
      det_peak_q <= det_peak_d;
    end
  end

  assign bus.det_peak = det_peak_q;
`else
  assign bus.det_peak = 12'd0;
`endif

  assign bus.det_valid = det_valid_q;
  assign bus.det_range = det_range_q;
  assign bus.det_width = det_width_q;
  assign bus.drop_cnt  = drop_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_stc_detector.sv
// Self-checking bench for stc_detector: directed sweep table, hand-written
// corner sequences and random sweeps compared against a sample-history model.
module tb_stc_detector;

  localparam int LIMIT = 2626;
  localparam int TH    = 512;
  localparam int MINR  = 3;

  logic clk;
  logic rst;
  stc_detector_if bus_if ();

  stc_detector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: keeps the current sweep's samples and derives each
  // closed run's range, width and peak from that history.
  int          hist[4096];
  int          m_bin;    // bin of the next sample, -1 outside a sweep
  int          m_start;  // first bin of the open run, -1 when none
  logic        ev;
  logic [11:0] er, ew, ep;
  logic [7:0]  ed;

  function automatic int pk(input int p);
`ifdef STC_DETECTOR_PEAK_EN
    return p;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_bin = -1; m_start = -1;
    ev = 1'b0; er = '0; ew = '0; ep = '0; ed = '0;
  endtask

  task automatic model_clock(input bit t, input int v, input bit r);
    int cur, last, mx, w;
    bit rep;
    rep = 1'b0; last = -1;
    cur = t ? 0 : m_bin;
    if (t) m_start = -1;
    if (cur >= 0) begin
      hist[cur] = v;
      if (v >= TH) begin
        if (m_start < 0) m_start = cur;
        if (cur == LIMIT - 1) last = cur;
      end else if (m_start >= 0) begin
        last = cur - 1;
      end
      if (last >= 0) begin
        w = last - m_start + 1;
        mx = 0;
        for (int b = m_start; b <= last; b++) if (hist[b] > mx) mx = hist[b];
        if (w >= MINR) begin
          rep = 1'b1;
          if (!ev || r) begin
            ev = 1'b1; er = 12'(m_start); ew = 12'(w); ep = 12'(pk(mx));
          end else if (ed != 8'hFF) begin
            ed = ed + 8'd1;
          end
        end
        m_start = -1;
      end
      m_bin = (cur == LIMIT - 1) ? -1 : cur + 1;
    end
    if (!rep && ev && r) ev = 1'b0;
  endtask

  function automatic logic [45:0] dut_pack();
    return {bus_if.det_valid, bus_if.det_range, bus_if.det_width,
            bus_if.det_peak, bus_if.drop_cnt, bus_if.busy};
  endfunction

  function automatic logic [45:0] exp_pack();
    return {ev, er, ew, ep, ed, (m_bin >= 0)};
  endfunction

  task automatic drive(input bit t, input int v, input bit r);
    bus_if.trig      = t;
    bus_if.vid_in    = 12'(v);
    bus_if.det_ready = r;
    @(posedge clk);
    model_clock(t, v, r);
    #1;
    check("cycle", dut_pack(), exp_pack());
  endtask

  int vid_arr[LIMIT];

  task automatic clear_vid();
    for (int i = 0; i < LIMIT; i++) vid_arr[i] = 0;
  endtask

  task automatic run_sweep(input bit rdy, output int rise);
    rise = -1;
    for (int i = 0; i < LIMIT; i++) begin
      drive(i == 0, vid_arr[i], rdy);
      if (rise < 0 && bus_if.det_valid) rise = i;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("reset_async", dut_pack(), 46'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    int start; int len; int base; int spike_bin; int spike_val;
    bit exp_rec; int exp_range; int exp_width; int exp_peak; int exp_rise;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int rise;
    vecs[0] = '{100,  5, 600, 102,  700, 1'b1, 100,  5, 700,  105};
    vecs[1] = '{200,  2, 600,  -1,    0, 1'b0,   0,  0,   0,   -1};
    vecs[2] = '{2623, 3, 600,  -1,    0, 1'b1, 2623, 3, 600, 2625};
    vecs[3] = '{0,    3, 600,   1,  800, 1'b1,   0,  3, 800,    3};
    vecs[4] = '{70,   3, 512,  -1,    0, 1'b1,  70,  3, 512,   73};
    vecs[5] = '{80,   6, 511,  -1,    0, 1'b0,   0,  0,   0,   -1};

    bus_if.trig = 1'b0; bus_if.vid_in = '0; bus_if.det_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    #5 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dut_pack(), 46'd0);
    rst = 1'b1;

    // Directed single-run sweeps with the consumer stalled.
    foreach (vecs[k]) begin
      clear_vid();
      for (int b = vecs[k].start; b < vecs[k].start + vecs[k].len; b++) vid_arr[b] = vecs[k].base;
      if (vecs[k].spike_bin >= 0) vid_arr[vecs[k].spike_bin] = vecs[k].spike_val;
      run_sweep(1'b0, rise);
      check("rise_bin", rise, vecs[k].exp_rise);
      check("rec_valid", bus_if.det_valid, vecs[k].exp_rec);
      if (vecs[k].exp_rec) begin
        check("rec_range", bus_if.det_range, vecs[k].exp_range);
        check("rec_width", bus_if.det_width, vecs[k].exp_width);
        check("rec_peak", bus_if.det_peak, pk(vecs[k].exp_peak));
      end
      drive(1'b0, 900, 1'b0);
      check("busy_after_sweep", bus_if.busy, 1'b0);
      check("drop_none", bus_if.drop_cnt, 8'd0);
      drive(1'b0, 0, 1'b1);
      check("accepted", bus_if.det_valid, 1'b0);
    end

    // Full buffer: second record dropped, first accepted exactly once.
    do_reset();
    clear_vid();
    for (int b = 300; b <= 303; b++) vid_arr[b] = 600;
    for (int b = 400; b <= 403; b++) vid_arr[b] = 650;
    run_sweep(1'b0, rise);
    check("held_valid", bus_if.det_valid, 1'b1);
    check("held_range", bus_if.det_range, 12'd300);
    check("held_width", bus_if.det_width, 12'd4);
    check("held_peak", bus_if.det_peak, pk(600));
    check("drop_one", bus_if.drop_cnt, 8'd1);
    drive(1'b0, 0, 1'b1);
    check("accept_once", bus_if.det_valid, 1'b0);
    drive(1'b0, 0, 1'b1);
    check("ready_no_valid", {bus_if.det_valid, bus_if.drop_cnt}, 9'd1);

    // Restart mid-run: the old run vanishes, the new bin 0 starts a run.
    clear_vid();
    vid_arr[500] = 600; vid_arr[501] = 600;
    for (int i = 0; i <= 501; i++) drive(i == 0, vid_arr[i], 1'b0);
    check("restart_pre", bus_if.det_valid, 1'b0);
    clear_vid();
    for (int b = 0; b <= 2; b++) vid_arr[b] = 600;
    run_sweep(1'b0, rise);
    check("restart_rise", rise, 3);
    check("restart_range", bus_if.det_range, 12'd0);
    check("restart_width", bus_if.det_width, 12'd3);
    drive(1'b0, 0, 1'b1);

    // Reset with a pending record and an open run.
    clear_vid();
    for (int b = 10; b <= 12; b++) vid_arr[b] = 600;
    for (int b = 20; b <= 25; b++) vid_arr[b] = 600;
    for (int i = 0; i <= 21; i++) drive(i == 0, vid_arr[i], 1'b0);
    check("pre_reset_valid", bus_if.det_valid, 1'b1);
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b0, 700, 1'b1);
    check("no_resume", {bus_if.det_valid, bus_if.busy}, 2'd0);

    // Random sweeps with random consumer stalls and rare restarts.
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < LIMIT + 20; i++) begin
        int v;
        int sel;
        bit t;
        sel = $urandom_range(0, 99);
        if (sel < 5)       v = 511;
        else if (sel < 10) v = 512;
        else if (sel < 40) v = $urandom_range(513, 4095);
        else               v = $urandom_range(0, 510);
        t = (i == 0) || ($urandom_range(0, 999) == 0);
        drive(t, v, $urandom_range(0, 3) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stc_detector.md
STC_DETECTOR -- requirements
Module: stc_detector

Interface
REQ-001 Parameter SAMPLE_LIMIT, default 12'd2626: number of range bins per sweep.
REQ-002 Parameter THRESHOLD, default 12'd512: detection threshold, unsigned.
REQ-003 Parameter MIN_RUN, default 12'd3: minimum consecutive above-threshold bins for a detection.
REQ-004 clk  input  1  system clock, 50 MHz, one video sample per cycle.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 trig  input  1  sweep start pulse; the sample in the trig cycle is bin 0.
REQ-007 vid_in  input  12  STC-compensated video, unsigned.
REQ-008 det_valid  output  1  detection record available.
REQ-009 det_ready  input  1  consumer accepts the record.
REQ-010 det_range  output  12  bin index of the first sample in the run.
REQ-011 det_width  output  12  run length in bins.
REQ-012 det_peak  output  12  maximum vid_in within the run.
REQ-013 drop_cnt  output  8  detections lost to a full output buffer, saturating.
REQ-014 busy  output  1  sweep active.

Function
REQ-015 Bin index SHALL equal clocks elapsed since the last trig cycle; the sweep SHALL cover bins 0..SAMPLE_LIMIT-1, and samples outside a sweep SHALL be ignored.
REQ-016 above SHALL be (vid_in >= THRESHOLD), unsigned compare.
REQ-017 FSM states: IDLE (no sweep), SEARCH (sweep, no open run), RUN (sweep, open run).
REQ-018 IDLE: trig -> evaluate bin 0 as in SEARCH; the resulting state is SEARCH or RUN.
REQ-019 SEARCH & above -> RUN; start=bin, width=1, peak=vid_in.
REQ-020 RUN & above -> width+1 (saturating at 4095); peak=max(peak, vid_in).
REQ-021 RUN & !above -> close run, go to SEARCH; the closing sample is not part of the run.
REQ-022 At bin SAMPLE_LIMIT-1 the FSM SHALL go to IDLE; an open run, including that bin, SHALL be closed.
REQ-023 trig during SEARCH/RUN SHALL restart the sweep at bin 0 and discard any open run without reporting it.
REQ-024 A closed run with width >= MIN_RUN SHALL be reported; shorter runs SHALL be discarded silently.
REQ-025 Output is a 1-entry buffer: a report SHALL load when det_valid=0 or (det_valid & det_ready) in the same cycle; otherwise it SHALL be dropped and drop_cnt SHALL increment, saturating at 255.
REQ-026 det_valid SHALL rise on the clock edge ending the closing cycle (1-cycle latency) and SHALL hold, with det_range/width/peak stable, until a cycle with det_ready=1.
REQ-027 det_ready without det_valid SHALL have no effect.
REQ-028 busy SHALL be 1 from the edge after trig through the edge after bin SAMPLE_LIMIT-1, and 0 in IDLE.

Reset
REQ-029 rst=0 SHALL immediately force: FSM to IDLE; det_valid, det_range, det_width, det_peak, drop_cnt, busy and the bin counter to 0.
REQ-030 A reset during a run or with a pending record SHALL discard both; after release, operation SHALL resume only on the next trig.

Configuration
REQ-031 Macro STC_DETECTOR_PEAK_EN: defined -> peak tracking per REQ-019/020 and det_peak driven from it; undefined -> no peak register and det_peak tied to 0, all other behaviour unchanged.

Verification
REQ-032 Bench SHALL cover (THRESHOLD=512, MIN_RUN=3):
- trig, bins 100-104 = 600 except bin 102 = 700, other bins 0 -> one record: range 100, width 5, peak 700 (0 without macro); det_valid rises after bin 105.
- run at bins 200-201 only -> no record, drop_cnt 0.
- det_ready=0, qualifying runs at 300-303 and 400-403 -> first record held, second dropped, drop_cnt=1; det_ready=1 -> the first record is accepted once.
- run at bins 2623-2625 -> record range 2623, width 3 at sweep end; a value of 900 at bin 2626 is ignored; busy falls.
- run starting at bin 500, trig at bin 502 -> no record from the old run; the new sweep's bin 0 is evaluated.
- rst=0 while det_valid=1 and a run is open -> all outputs 0 immediately; no record after release without trig.
